main_memory: RTL and testbench



---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_array.sv | 23 ++
 rtl/main_memory.sv | 82 ++++++++
 tb/tb_main_memory.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, default latencies and FSM state codes for main_memory
package mem_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int IDX_W = ADDR_W - 2;
  localparam int RD_LAT_DEF = 4;
  localparam int WR_LAT_DEF = 4;
  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    BUSY    = 4'b0010,
    DONE    = 4'b0100,
    RECOVER = 4'b1000
  } state_t;
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous RAM with write enable and registered, enable-gated read port
module mem_array #(
  parameter int AW = mem_pkg::IDX_W,
  parameter int DW = mem_pkg::DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW] = '{default: '0};
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
  // rdata only moves on a read, so it doubles as the held dataout register
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/main_memory.sv
// main_memory: fixed-latency word memory behind the cache, level req / pulsed rdy handshake
module main_memory #(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W,
  parameter int RD_LAT = mem_pkg::RD_LAT_DEF,
  parameter int WR_LAT = mem_pkg::WR_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] memaddr,
  input  logic              req,
  input  logic              rw,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout,
  output logic              rdy,
  output logic              busy
);
  import mem_pkg::*;
  localparam int IW = ADDR_W - 2;
  localparam int CW = $clog2((RD_LAT > WR_LAT ? RD_LAT : WR_LAT) + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic op_rw;
  logic [DATA_W-1:0] wdata;
  logic commit;
  logic unused_bits;
  assign unused_bits = ^memaddr[1:0];
  // the array is touched only on the BUSY->DONE edge
  assign commit = !rst && state == BUSY && req && cnt == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rdy <= 1'b0;
      busy <= 1'b0;
      cnt <= '0;
      idx <= '0;
      op_rw <= 1'b0;
      wdata <= '0;
    end else begin
      unique case (state)
        IDLE: if (req) begin
          idx <= memaddr[ADDR_W-1:2];
          op_rw <= rw;
          wdata <= datain;
          cnt <= rw ? CW'(WR_LAT - 1) : CW'(RD_LAT - 1);
          state <= BUSY;
          busy <= 1'b1;
        end
        BUSY: if (!req) begin
          state <= IDLE;
          busy <= 1'b0;
        end else if (cnt == '0) begin
          state <= DONE;
          rdy <= 1'b1;
        end else cnt <= cnt - 1'b1;
        DONE: begin
          rdy <= 1'b0;
          state <= RECOVER;
        end
        RECOVER: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
          rdy <= 1'b0;
        end
      endcase
    end
  end
  mem_array #(.AW(IW), .DW(DATA_W)) u_array (
    .clk(clk),
    .rst(rst),
    .we(commit & op_rw),
    .re(commit & ~op_rw),
    .addr(idx),
    .wdata(wdata),
    .rdata(dataout)
  );
endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory: directed and random checks of two main_memory instances (latency 4 and 1) against a word-array model
module tb_main_memory;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] rst, req, rw, rdy, busy;
  logic [15:0] addr [2];
  logic [31:0] din [2];
  logic [31:0] dout [2];
  logic [31:0] mdl [2][16384];
  logic [31:0] last [2];
  int lat_rd [2];
  int lat_wr [2];
  int checks = 0;
  int failures = 0;
  main_memory #(.RD_LAT(4), .WR_LAT(4)) u0 (
    .clk(clk), .rst(rst[0]), .memaddr(addr[0]), .req(req[0]), .rw(rw[0]),
    .datain(din[0]), .dataout(dout[0]), .rdy(rdy[0]), .busy(busy[0])
  );
  main_memory #(.RD_LAT(1), .WR_LAT(1)) u1 (
    .clk(clk), .rst(rst[1]), .memaddr(addr[1]), .req(req[1]), .rw(rw[1]),
    .datain(din[1]), .dataout(dout[1]), .rdy(rdy[1]), .busy(busy[1])
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  // one full transaction; inputs other than req are scrambled while busy to prove they were latched
  task automatic txn(input int d, input logic w, input logic [15:0] a, input logic [31:0] data);
    int n;
    int lat;
    logic bsy_ok;
    lat = w ? lat_wr[d] : lat_rd[d];
    bsy_ok = 1'b1;
    @(negedge clk);
    req[d] = 1'b1; rw[d] = w; addr[d] = a; din[d] = data;
    @(posedge clk);
    for (n = 0; n < 64; n++) begin
      @(negedge clk);
      if (rdy[d] === 1'b1) break;
      bsy_ok &= (busy[d] === 1'b1);
      addr[d] = 16'($urandom); din[d] = $urandom; rw[d] = 1'($urandom);
    end
    check("latency", 32'(n), 32'(lat));
    check("busy_during", 32'(bsy_ok), 32'd1);
    if (n < 64) begin
      if (w) mdl[d][a[15:2]] = data;
      else last[d] = mdl[d][a[15:2]];
      check("dataout", dout[d], last[d]);
      check("busy_done", 32'(busy[d]), 32'd1);
    end
    req[d] = 1'b0;
    @(negedge clk);
    check("recover", {30'd0, busy[d], rdy[d]}, 32'd2);
    @(negedge clk);
    check("idle_busy", 32'(busy[d]), 32'd0);
  endtask
  initial begin
    int n;
    logic seen;
    lat_rd[0] = 4; lat_wr[0] = 4; lat_rd[1] = 1; lat_wr[1] = 1;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16384; i++) mdl[d][i] = '0;
      last[d] = '0; addr[d] = '0; din[d] = '0;
    end
    rst = 2'b11; req = 2'b00; rw = 2'b00;
    repeat (2) @(negedge clk);
    rst = 2'b00;
    for (int d = 0; d < 2; d++) begin
      check("reset_rdy", 32'(rdy[d]), 32'd0);
      check("reset_busy", 32'(busy[d]), 32'd0);
      check("reset_dout", dout[d], 32'd0);
    end
    txn(0, 1'b0, 16'h0040, 32'h0);
    txn(0, 1'b1, 16'h1234, 32'hDEADBEEF);
    txn(0, 1'b0, 16'h1237, 32'h0);
    check("byte_offset_ignored", dout[0], 32'hDEADBEEF);
    // req held across rdy; rw flipped to read in the cycle after rdy
    @(negedge clk);
    req[0] = 1'b1; rw[0] = 1'b1; addr[0] = 16'h0300; din[0] = 32'h11112222;
    @(posedge clk);
    for (n = 0; n < 64; n++) begin
      @(negedge clk);
      if (rdy[0] === 1'b1) break;
    end
    check("hold_wr_latency", 32'(n), 32'd4);
    mdl[0][16'h0300 >> 2] = 32'h11112222;
    @(negedge clk);
    check("hold_recover_busy", 32'(busy[0]), 32'd1);
    rw[0] = 1'b0; addr[0] = 16'h1234;
    @(negedge clk);
    check("hold_idle_busy", 32'(busy[0]), 32'd0);
    @(posedge clk);
    for (n = 0; n < 64; n++) begin
      @(negedge clk);
      if (rdy[0] === 1'b1) break;
    end
    check("hold_rd_latency", 32'(n), 32'd4);
    check("hold_is_read", dout[0], 32'hDEADBEEF);
    last[0] = 32'hDEADBEEF;
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    txn(0, 1'b0, 16'h0300, 32'h0);
    // abort after two BUSY cycles
    @(negedge clk);
    req[0] = 1'b1; rw[0] = 1'b1; addr[0] = 16'h0100; din[0] = 32'hA5A5A5A5;
    @(posedge clk);
    repeat (2) @(negedge clk);
    req[0] = 1'b0;
    seen = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy[0]), 32'd0);
    repeat (6) begin
      seen |= rdy[0];
      @(negedge clk);
    end
    check("abort_no_rdy", 32'(seen), 32'd0);
    check("abort_dout", dout[0], last[0]);
    txn(0, 1'b0, 16'h0100, 32'h0);
    // reset in the middle of a write
    @(negedge clk);
    req[0] = 1'b1; rw[0] = 1'b1; addr[0] = 16'h0200; din[0] = 32'hCAFEF00D;
    @(posedge clk);
    repeat (2) @(negedge clk);
    rst[0] = 1'b1; req[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b0;
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_rdy", 32'(rdy[0]), 32'd0);
    check("rst_dout", dout[0], 32'd0);
    last[0] = '0;
    txn(0, 1'b0, 16'h0200, 32'h0);
    txn(0, 1'b0, 16'h1234, 32'h0);
    // single-cycle latency instance, datain scrambled before commit
    txn(1, 1'b1, 16'h0010, 32'h0BADF00D);
    txn(1, 1'b0, 16'h0012, 32'h0);
    for (int i = 0; i < 40; i++)
      txn(0, 1'($urandom), 16'h0800 + 16'($urandom_range(0, 7) << 2) + 16'($urandom_range(0, 3)), $urandom);
    for (int i = 0; i < 30; i++)
      txn(1, 1'($urandom), 16'h0800 + 16'($urandom_range(0, 7) << 2) + 16'($urandom_range(0, 3)), $urandom);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
